// File: rtl/perf_counter_bank.sv
// perf_counter_bank
// Eight free-running performance event counters fed by a pipeline observation
// port. Counts can be frozen, cleared, or copied into shadow registers. The
// shadow registers are read one at a time through a registered read port.
// The block only watches the pipeline and never drives anything back into it.
module perf_counter_bank #(
  parameter int CNT_W    = 16,
  parameter int SATURATE = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             valid,
  input  logic [3:0]       Op,
  input  logic             stall,
  input  logic             kill,
  input  logic             clr,
  input  logic             snap,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic [7:0]       ovf
);

  // Opcode encodings, matching the pipeline's opcodes.v
  localparam logic [3:0] OP_ALU  = 4'b0000;
  localparam logic [3:0] OP_CTRL = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_ANDI = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_BNE  = 4'b0111;
  localparam logic [3:0] OP_FOR  = 4'b1000;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             isAlu;
  logic             isCtrl;
  logic             isLw;
  logic             isSw;
  logic             recognised;
  logic             retire;
  logic [7:0]       incVec;
  logic [CNT_W-1:0] cnt_q    [8];
  logic [CNT_W-1:0] cnt_d    [8];
  logic [CNT_W-1:0] shadow_q [8];
  logic [CNT_W-1:0] rdData_q;
  logic [7:0]       ovf_q;
  logic [7:0]       ovf_d;

  // Decode the opcode class. Build the per-counter event vector in this order:
  // EX, LW, SW, ALU, CTRL, CLK, STALL, KILL.
  // FOR counts as both an ALU op and a control op.
  always_comb begin
    isAlu      = (Op == OP_ALU) || (Op == OP_ANDI) || (Op == OP_ADDI) || (Op == OP_FOR);
    isCtrl     = (Op == OP_CTRL) || (Op == OP_BEQ) || (Op == OP_BNE) || (Op == OP_FOR);
    isLw       = (Op == OP_LW);
    isSw       = (Op == OP_SW);
    recognised = isAlu | isCtrl | isLw | isSw;
    retire     = valid & ~stall & ~kill & recognised;
    incVec     = 8'b0;
    incVec[0]  = retire;
    incVec[1]  = retire & isLw;
    incVec[2]  = retire & isSw;
    incVec[3]  = retire & isAlu;
    incVec[4]  = retire & isCtrl;
    incVec[5]  = 1'b1;
    incVec[6]  = stall | kill;
    incVec[7]  = kill;
  end

  // Compute the next live count and overflow flag for each counter.
  // Clear beats any same-cycle increment.
  // At the maximum value a counter either wraps or holds, and in both cases its sticky flag is set.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (clr) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (en && incVec[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SATURATE != 0) ? CNT_MAX : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Update the live counters, the flags, the snapshot shadows and the registered read port.
  // Snapshots and reads both use the values held before this edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      ovf_q    <= '0;
      rdData_q <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (snap) begin
          shadow_q[i] <= cnt_q[i];
        end
      end
      ovf_q    <= ovf_d;
      rdData_q <= shadow_q[rd_sel];
    end
  end

  assign rd_data = rdData_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank
// Drives a wide wrapping bank, a 4-bit wrapping bank and a 4-bit saturating bank
// from the same stimulus. Expected shadow reads are queued as each read is issued
// and checked once the registered read data appears.
module tb_perf_counter_bank;

  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_FOR  = 4'b1000;
  localparam logic [3:0] OP_BAD  = 4'b1111;

  logic        CLK;
  logic        RST;
  logic        en;
  logic        valid;
  logic [3:0]  Op;
  logic        stall;
  logic        kill;
  logic        clr;
  logic        snap;
  logic [2:0]  rd_sel;
  logic [15:0] rdData;
  logic [3:0]  rdW;
  logic [3:0]  rdS;
  logic [7:0]  ovfM;
  logic [7:0]  ovfW;
  logic [7:0]  ovfS;

  int          checks;
  int          errors;
  logic [15:0] expQ [$];
  logic [15:0] expV;
  logic [15:0] gm;
  logic [3:0]  gw;
  logic [3:0]  gs;

  perf_counter_bank #(.CNT_W(16), .SATURATE(0)) dut (
    .CLK(CLK), .RST(RST), .en(en), .valid(valid), .Op(Op), .stall(stall),
    .kill(kill), .clr(clr), .snap(snap), .rd_sel(rd_sel), .rd_data(rdData), .ovf(ovfM)
  );

  perf_counter_bank #(.CNT_W(4), .SATURATE(0)) dutW (
    .CLK(CLK), .RST(RST), .en(en), .valid(valid), .Op(Op), .stall(stall),
    .kill(kill), .clr(clr), .snap(snap), .rd_sel(rd_sel), .rd_data(rdW), .ovf(ovfW)
  );

  perf_counter_bank #(.CNT_W(4), .SATURATE(1)) dutS (
    .CLK(CLK), .RST(RST), .en(en), .valid(valid), .Op(Op), .stall(stall),
    .kill(kill), .clr(clr), .snap(snap), .rd_sel(rd_sel), .rd_data(rdS), .ovf(ovfS)
  );

  // Free-running clock with a 10-unit period
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    en     = 1'b0;
    valid  = 1'b0;
    Op     = 4'b0;
    stall  = 1'b0;
    kill   = 1'b0;
    clr    = 1'b0;
    snap   = 1'b0;
    rd_sel = 3'd0;
    RST    = 1'b1;
    #2;
    RST    = 1'b0;
  endtask

  task automatic countCycles(input int n);
    en = 1'b1;
    repeat (n) tick();
    en = 1'b0;
  endtask

  task automatic pulseSnap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic readShadow(input logic [2:0] k, output logic [15:0] g,
                            output logic [3:0] w, output logic [3:0] s);
    rd_sel = k;
    tick();
    g = rdData;
    w = rdW;
    s = rdS;
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (rdData !== 16'd0) begin errors++; $display("[TB] FAIL reset_rd_data got %0d expected 0", rdData); end
    checks++;
    if (ovfM !== 8'h00) begin errors++; $display("[TB] FAIL reset_ovf got %h expected 00", ovfM); end
    checks++;
    if (ovfW !== 8'h00 || ovfS !== 8'h00) begin errors++; $display("[TB] FAIL reset_ovf_small got %h/%h expected 00/00", ovfW, ovfS); end
    for (int k = 0; k < 8; k++) begin
      expQ.push_back(16'd0);
      readShadow(3'(k), gm, gw, gs);
      expV = expQ.pop_front();
      checks++;
      if (gm !== expV) begin errors++; $display("[TB] FAIL reset_shadow%0d got %0d expected %0d", k, gm, expV); end
    end
  endtask

  task automatic test_clk_count();
    doReset();
    countCycles(10);
    pulseSnap();
    for (int k = 0; k < 8; k++) begin
      expQ.push_back((k == 5) ? 16'd10 : 16'd0);
      readShadow(3'(k), gm, gw, gs);
      expV = expQ.pop_front();
      checks++;
      if (gm !== expV) begin errors++; $display("[TB] FAIL clk_count_shadow%0d got %0d expected %0d", k, gm, expV); end
    end
  endtask

  task automatic test_opcode_classes();
    logic [3:0]  ops [6];
    logic [15:0] e [8];
    ops = '{OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_FOR, OP_BAD};
    e   = '{16'd5, 16'd1, 16'd1, 16'd2, 16'd2, 16'd6, 16'd0, 16'd0};
    doReset();
    en    = 1'b1;
    valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      Op = ops[i];
      tick();
    end
    en    = 1'b0;
    valid = 1'b0;
    pulseSnap();
    for (int k = 0; k < 8; k++) begin
      expQ.push_back(e[k]);
      readShadow(3'(k), gm, gw, gs);
      expV = expQ.pop_front();
      checks++;
      if (gm !== expV) begin errors++; $display("[TB] FAIL opclass_shadow%0d got %0d expected %0d", k, gm, expV); end
    end
  endtask

  task automatic test_stall_kill();
    logic [15:0] e [8];
    e = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd5, 16'd5, 16'd2};
    doReset();
    en    = 1'b1;
    valid = 1'b1;
    Op    = OP_LW;
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    kill  = 1'b1;
    repeat (2) tick();
    kill  = 1'b0;
    valid = 1'b0;
    en    = 1'b0;
    pulseSnap();
    for (int k = 0; k < 8; k++) begin
      expQ.push_back(e[k]);
      readShadow(3'(k), gm, gw, gs);
      expV = expQ.pop_front();
      checks++;
      if (gm !== expV) begin errors++; $display("[TB] FAIL stallkill_shadow%0d got %0d expected %0d", k, gm, expV); end
    end
  endtask

  task automatic test_overflow();
    doReset();
    countCycles(17);
    checks++;
    if (ovfW !== 8'h20) begin errors++; $display("[TB] FAIL wrap_ovf got %h expected 20", ovfW); end
    checks++;
    if (ovfS !== 8'h20) begin errors++; $display("[TB] FAIL sat_ovf got %h expected 20", ovfS); end
    checks++;
    if (ovfM !== 8'h00) begin errors++; $display("[TB] FAIL wide_ovf got %h expected 00", ovfM); end
    pulseSnap();
    expQ.push_back(16'd1);
    expQ.push_back(16'd15);
    expQ.push_back(16'd17);
    readShadow(3'd5, gm, gw, gs);
    expV = expQ.pop_front();
    checks++;
    if ({12'h0, gw} !== expV) begin errors++; $display("[TB] FAIL wrap_clk got %0d expected %0d", gw, expV); end
    expV = expQ.pop_front();
    checks++;
    if ({12'h0, gs} !== expV) begin errors++; $display("[TB] FAIL sat_clk got %0d expected %0d", gs, expV); end
    expV = expQ.pop_front();
    checks++;
    if (gm !== expV) begin errors++; $display("[TB] FAIL wide_clk got %0d expected %0d", gm, expV); end
    countCycles(1);
    checks++;
    if (ovfW !== 8'h20) begin errors++; $display("[TB] FAIL ovf_sticky got %h expected 20", ovfW); end
  endtask

  task automatic test_clr_snap();
    doReset();
    countCycles(16);
    checks++;
    if (ovfW !== 8'h20) begin errors++; $display("[TB] FAIL pre_clr_ovf got %h expected 20", ovfW); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (ovfW !== 8'h00) begin errors++; $display("[TB] FAIL clr_ovf got %h expected 00", ovfW); end
    countCycles(7);
    en   = 1'b1;
    clr  = 1'b1;
    snap = 1'b1;
    tick();
    en   = 1'b0;
    clr  = 1'b0;
    snap = 1'b0;
    checks++;
    if (ovfM !== 8'h00 || ovfW !== 8'h00) begin errors++; $display("[TB] FAIL clrsnap_ovf got %h/%h expected 00/00", ovfM, ovfW); end
    expQ.push_back(16'd7);
    readShadow(3'd5, gm, gw, gs);
    expV = expQ.pop_front();
    checks++;
    if (gm !== expV) begin errors++; $display("[TB] FAIL clrsnap_shadow_clk got %0d expected %0d", gm, expV); end
    countCycles(3);
    pulseSnap();
    expQ.push_back(16'd3);
    readShadow(3'd5, gm, gw, gs);
    expV = expQ.pop_front();
    checks++;
    if (gm !== expV) begin errors++; $display("[TB] FAIL post_clr_clk got %0d expected %0d", gm, expV); end
  endtask

  task automatic test_back_to_back();
    countCycles(2);
    rd_sel = 3'd5;
    snap   = 1'b1;
    expQ.push_back(16'd3);
    tick();
    snap = 1'b0;
    expV = expQ.pop_front();
    checks++;
    if (rdData !== expV) begin errors++; $display("[TB] FAIL read_during_snap got %0d expected %0d", rdData, expV); end
    expQ.push_back(16'd5);
    tick();
    expV = expQ.pop_front();
    checks++;
    if (rdData !== expV) begin errors++; $display("[TB] FAIL read_after_snap got %0d expected %0d", rdData, expV); end
    valid = 1'b1;
    Op    = OP_ADDI;
    stall = 1'b1;
    kill  = 1'b1;
    repeat (4) tick();
    valid = 1'b0;
    stall = 1'b0;
    kill  = 1'b0;
    pulseSnap();
    for (int k = 5; k < 8; k++) begin
      expQ.push_back((k == 5) ? 16'd5 : 16'd0);
      readShadow(3'(k), gm, gw, gs);
      expV = expQ.pop_front();
      checks++;
      if (gm !== expV) begin errors++; $display("[TB] FAIL frozen_shadow%0d got %0d expected %0d", k, gm, expV); end
    end
  endtask

  task automatic test_async_reset();
    doReset();
    countCycles(20);
    pulseSnap();
    expQ.push_back(16'd20);
    readShadow(3'd5, gm, gw, gs);
    expV = expQ.pop_front();
    checks++;
    if (gm !== expV) begin errors++; $display("[TB] FAIL pre_rst_clk got %0d expected %0d", gm, expV); end
    en = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (rdData !== 16'd0) begin errors++; $display("[TB] FAIL async_rd_data got %0d expected 0", rdData); end
    checks++;
    if (ovfW !== 8'h00 || ovfS !== 8'h00) begin errors++; $display("[TB] FAIL async_ovf got %h/%h expected 00/00", ovfW, ovfS); end
    #2;
    RST = 1'b0;
    en  = 1'b0;
    expQ.push_back(16'd0);
    readShadow(3'd5, gm, gw, gs);
    expV = expQ.pop_front();
    checks++;
    if (gm !== expV) begin errors++; $display("[TB] FAIL async_shadow got %0d expected %0d", gm, expV); end
    countCycles(1);
    pulseSnap();
    expQ.push_back(16'd1);
    readShadow(3'd5, gm, gw, gs);
    expV = expQ.pop_front();
    checks++;
    if (gm !== expV) begin errors++; $display("[TB] FAIL first_after_rst got %0d expected %0d", gm, expV); end
  endtask

  // Run each scenario in turn, then report totals
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_clk_count();
    test_opcode_classes();
    test_stall_kill();
    test_overflow();
    test_clr_snap();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter CNT_W, default 16, width of every counter; legal range 2..32.
REQ-002 Parameter SATURATE, default 0; 0 = counters wrap, 1 = counters saturate at 2^CNT_W-1.
REQ-003 Port CLK  input  1  sole clock, rising edge.
REQ-004 Port RST  input  1  asynchronous, active-high reset.
REQ-005 Port en  input  1  counting enable; 0 freezes all eight counters.
REQ-006 Port valid  input  1  an instruction is present in the sampled stage this cycle.
REQ-007 Port Op  input  4  opcode of that instruction, encoded per opcodes.v.
REQ-008 Port stall  input  1  pipeline stall this cycle.
REQ-009 Port kill  input  1  instruction killed this cycle.
REQ-010 Port clr  input  1  single-cycle pulse; zeroes live counters and overflow flags.
REQ-011 Port snap  input  1  single-cycle pulse; copies all live counters into shadow registers.
REQ-012 Port rd_sel  input  3  shadow counter index to read.
REQ-013 Port rd_data  output  CNT_W  registered read of shadow[rd_sel].
REQ-014 Port ovf  output  8  sticky per-counter overflow flags, bit i for counter i.

Function
REQ-015 Counter index map: 0 EX, 1 LW, 2 SW, 3 ALU, 4 CTRL, 5 CLK, 6 STALL, 7 KILL.
REQ-016 Opcode classes: ALU = 4'b0000, ANDI, ADDI; LW = LW; SW = SW; CTRL = 4'b0001, BEQ, BNE; FOR = both ALU and CTRL; all other opcodes are unrecognised.
REQ-017 retire = valid & ~stall & ~kill & (Op recognised).
REQ-018 With en=1, each rising edge increments: CLK always; STALL if stall|kill; KILL if kill; EX if retire; LW/SW/ALU/CTRL if retire and Op is in that class (FOR increments both ALU and CTRL).
REQ-019 With en=0, no live counter changes; clr and snap still act.
REQ-020 Increment is +1 only; no counter changes by more than 1 per cycle.
REQ-021 SATURATE=0: a counter at 2^CNT_W-1 that increments becomes 0 and sets its ovf bit.
REQ-022 SATURATE=1: a counter at 2^CNT_W-1 that increments holds its value and sets its ovf bit.
REQ-023 ovf bits are sticky; they clear only on clr or RST.
REQ-024 clr: all live counters and ovf become 0 at the edge; clr has priority over any increment in the same cycle (result 0, not 1).
REQ-025 snap: shadow[i] <= live counter i value before that edge's increment/clear.
REQ-026 snap and clr in the same cycle: shadow captures pre-clear values; live counters become 0.
REQ-027 rd_data updates one cycle after rd_sel is sampled: rd_data <= shadow[rd_sel] as held before the same edge; a read coinciding with snap returns the old shadow value.
REQ-028 Shadow registers change only on snap or RST.
REQ-029 The block is observation-only; it has no outputs into the pipeline and imposes no stall.

Reset
REQ-030 RST=1 asynchronously zeroes all live counters, all shadow registers, ovf and rd_data, independent of CLK.
REQ-031 RST asserted mid-count discards all accumulated values; the first counting edge after RST deasserts yields value 1 in CLK.
REQ-032 No initial-block or simulation-only display logic; all state is reset-defined.

Verification
REQ-033 Reset, en=1, valid=0 for 10 cycles, snap, rd_sel=5 -> rd_data=10; every other index reads 0.
REQ-034 Retire ADDI, LW, SW, BEQ, FOR, then an unrecognised Op, with stall=kill=0, then snap -> EX=5, ALU=2, LW=1, SW=1, CTRL=2.
REQ-035 valid=1 LW with stall=1 for 3 cycles, then kill=1 for 2 cycles -> STALL=5, KILL=2, LW=0, EX=0.
REQ-036 CNT_W=4, SATURATE=0: 17 cycles -> CLK=1, ovf[5]=1; SATURATE=1: 17 cycles -> CLK=15, ovf[5]=1.
REQ-037 clr and snap in the same cycle after 7 cycles -> shadow CLK=7, live CLK=0, ovf=0; next snap after 3 further cycles -> CLK=3.
REQ-038 Assert RST asynchronously between edges during counting -> all counters, shadow, ovf and rd_data read 0 immediately.
